// File: rtl/transfer_link_decoder_pkg.sv
// Shared codes, state encoding and error bit positions for the transfer link decoder.
package transfer_link_pkg;

  localparam int CMD_FLUSH    = 1;
  localparam int CMD_ENABLE_A = 2;
  localparam int CMD_SCAN     = 3;
  localparam int CMD_ENABLE_B = 4;
  localparam int CMD_ENABLE_C = 5;
  localparam int CMD_STATUS   = 6;
  localparam int CMD_BINARY   = 7;
  localparam int CMD_ASCII    = 8;

  localparam logic [1:0] SCAN_IDLE  = 2'b00;
  localparam logic [1:0] SCAN_FLUSH = 2'b10;
  localparam logic [1:0] SCAN_START = 2'b01;

  localparam int ERR_CMD      = 0;
  localparam int ERR_FRAME    = 1;
  localparam int ERR_OVERFLOW = 2;

  typedef enum logic [1:0] {
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD
  } linkState_t;

  function automatic logic lenInRange(input logic [31:0] len, input int unsigned maxLen);
    return (len != 32'd0) && (len <= maxLen);
  endfunction

endpackage

// File: rtl/transfer_link_decoder_if.sv
// Serial input, scanner/status outputs and payload ready/valid bus of the transfer link decoder.
interface transfer_link_decoder_if #(
  parameter int WORD_W = 8
);
  logic              dataIn;
  logic              dataValid;
  logic              readyForTransferIn;
  logic              readyForTransferOut;
  logic [1:0]        localScannerOut;
  logic [WORD_W-1:0] payloadOut;
  logic              payloadAscii;
  logic              payloadLast;
  logic              payloadValid;
  logic              payloadReady;
  logic              statusReq;
  logic [2:0]        errPulse;

  modport master (
    output dataIn, dataValid, readyForTransferIn, payloadReady,
    input  readyForTransferOut, localScannerOut, payloadOut, payloadAscii,
           payloadLast, payloadValid, statusReq, errPulse
  );

  modport slave (
    input  dataIn, dataValid, readyForTransferIn, payloadReady,
    output readyForTransferOut, localScannerOut, payloadOut, payloadAscii,
           payloadLast, payloadValid, statusReq, errPulse
  );
endinterface

// File: rtl/transfer_link_decoder_fifo.sv
// Synchronous payload FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module transfer_payload_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPop  = i_pop & ~o_empty;
  assign w_doPush = i_push & (~o_full | w_doPop);
  // Head is masked while empty so stale storage never appears on the outputs after reset.
  assign o_rdata  = o_empty ? '0 : r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/transfer_link_decoder.sv
// Serial command/payload receiver: deserialiser, command/frame FSM, idle timeout and payload FIFO.
module transfer_link_decoder
  import transfer_link_pkg::*;
#(
  parameter int WORD_W     = 8,
  parameter int MAX_LEN    = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  transfer_link_decoder_if.slave  bus
);
  localparam int BC_W   = $clog2(WORD_W);
  localparam int REM_W  = $clog2(MAX_LEN + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 2);
  localparam int FIFO_W = WORD_W + 2;

  linkState_t          r_state;
  logic [WORD_W-2:0]   r_shift;
  logic [BC_W-1:0]     r_bitCnt;
  logic [REM_W-1:0]    r_remaining;
  logic [IDLE_W-1:0]   r_idle;
  logic                r_ascii;
  logic                r_transferEn;
  logic                r_readyOut;
  logic [1:0]          r_scanner;
  logic                r_statusReq;
  logic [2:0]          r_err;

  logic [WORD_W-1:0]   w_word;
  logic [31:0]         w_wordInt;
  logic                w_wordDone;
  logic                w_push;
  logic                w_last;
  logic                w_overflow;
  logic                w_idleRun;
  logic [IDLE_W-1:0]   w_idleNext;
  logic                w_timeout;
  logic                w_full;
  logic                w_empty;
  logic [FIFO_W-1:0]   w_head;

  assign w_word     = {r_shift, bus.dataIn};
  assign w_wordInt  = 32'(w_word);
  assign w_wordDone = bus.dataValid && (r_bitCnt == BC_W'(WORD_W - 1));
  assign w_push     = w_wordDone && (r_state == ST_PAYLOAD);
  assign w_last     = (r_remaining == REM_W'(1));
  // Full with no pop means the word is lost; a simultaneous pop makes room.
  assign w_overflow = w_push & w_full & ~bus.payloadReady;
  assign w_idleRun  = !bus.dataValid && ((r_bitCnt != '0) || (r_state != ST_CMD));
  assign w_idleNext = r_idle + IDLE_W'(1);
  assign w_timeout  = (TIMEOUT > 0) && w_idleRun && (w_idleNext == IDLE_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_CMD;
      r_shift      <= '0;
      r_bitCnt     <= '0;
      r_remaining  <= '0;
      r_idle       <= '0;
      r_ascii      <= 1'b0;
      r_transferEn <= 1'b0;
      r_readyOut   <= 1'b0;
      r_scanner    <= SCAN_IDLE;
      r_statusReq  <= 1'b0;
      r_err        <= '0;
    end else begin
      r_scanner   <= SCAN_IDLE;
      r_statusReq <= 1'b0;
      r_err       <= '0;
      r_readyOut  <= r_transferEn & bus.readyForTransferIn;
      if (w_overflow) r_err[ERR_OVERFLOW] <= 1'b1;

      if (bus.dataValid) begin
        r_idle  <= '0;
        r_shift <= w_word[WORD_W-2:0];
        if (w_wordDone) begin
          r_bitCnt <= '0;
          case (r_state)
            ST_CMD: begin
              case (w_wordInt)
                CMD_FLUSH: begin
                  r_scanner    <= SCAN_FLUSH;
                  r_transferEn <= 1'b0;
                end
                CMD_ENABLE_A, CMD_ENABLE_B, CMD_ENABLE_C: r_transferEn <= 1'b1;
                CMD_SCAN: begin
                  r_transferEn <= 1'b1;
                  r_scanner    <= SCAN_START;
                end
                CMD_STATUS: r_statusReq <= 1'b1;
                CMD_BINARY: begin
                  r_ascii <= 1'b0;
                  r_state <= ST_LEN;
                end
                CMD_ASCII: begin
                  r_ascii <= 1'b1;
                  r_state <= ST_LEN;
                end
                default: r_err[ERR_CMD] <= 1'b1;
              endcase
            end
            ST_LEN: begin
              if (lenInRange(w_wordInt, MAX_LEN)) begin
                r_remaining <= REM_W'(w_wordInt);
                r_state     <= ST_PAYLOAD;
              end else begin
                r_err[ERR_FRAME] <= 1'b1;
                r_state          <= ST_CMD;
              end
            end
            ST_PAYLOAD: begin
              // ASCII words must be 7-bit; offending words are still delivered but flagged.
              if (r_ascii && w_word[WORD_W-1]) r_err[ERR_FRAME] <= 1'b1;
              r_remaining <= r_remaining - REM_W'(1);
              if (w_last) r_state <= ST_CMD;
            end
            default: r_state <= ST_CMD;
          endcase
        end else begin
          r_bitCnt <= r_bitCnt + BC_W'(1);
        end
      end else if (w_idleRun) begin
        if (w_timeout) begin
          r_idle           <= '0;
          r_bitCnt         <= '0;
          r_state          <= ST_CMD;
          r_err[ERR_FRAME] <= 1'b1;
        end else begin
          r_idle <= w_idleNext;
        end
      end else begin
        r_idle <= '0;
      end
    end
  end

  transfer_payload_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({w_word, r_ascii, w_last}),
    .i_pop   (bus.payloadReady),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.readyForTransferOut = r_readyOut;
  assign bus.localScannerOut     = r_scanner;
  assign bus.statusReq           = r_statusReq;
  assign bus.errPulse            = r_err;
  assign bus.payloadOut          = w_head[FIFO_W-1:2];
  assign bus.payloadAscii        = w_head[1];
  assign bus.payloadLast         = w_head[0];
  assign bus.payloadValid        = ~w_empty;
endmodule

// File: tb/tb_transfer_link_decoder.sv
// Directed bench for transfer_link_decoder; payload words are tracked through a scoreboard queue.
module tb_transfer_link_decoder;
  localparam int WORD_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nVectors = 0;
  int   nMiscompares = 0;
  logic [WORD_W+1:0] scoreboard [$];

  transfer_link_decoder_if #(.WORD_W(WORD_W)) bus ();

  transfer_link_decoder #(
    .WORD_W     (WORD_W),
    .MAX_LEN    (16),
    .FIFO_DEPTH (16),
    .TIMEOUT    (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic pushExpected(input logic [WORD_W-1:0] word, input logic ascii, input logic last);
    scoreboard.push_back({word, ascii, last});
  endtask

  // Shifts one word MSB-first; optionally pops the FIFO head on the same edge as the last bit.
  task automatic applyStimulus(input logic [WORD_W-1:0] word, input bit popOnLast = 1'b0);
    logic [WORD_W+1:0] expHead;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      bus.dataIn    = word[i];
      bus.dataValid = 1'b1;
      if (i == 0 && popOnLast) begin
        checkOutput("popHeadValid", 32'(bus.payloadValid), 32'(1));
        if (scoreboard.size() > 0) begin
          expHead = scoreboard.pop_front();
          checkOutput("popHead", 32'({bus.payloadOut, bus.payloadAscii, bus.payloadLast}), 32'(expHead));
        end
        bus.payloadReady = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.dataValid    = 1'b0;
    bus.payloadReady = 1'b0;
  endtask

  task automatic sendBits(input int n);
    for (int i = 0; i < n; i++) begin
      bus.dataIn    = i[0];
      bus.dataValid = 1'b1;
      @(posedge clk); #1;
    end
    bus.dataValid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drainPayload();
    logic [WORD_W+1:0] expHead;
    int budget = 200;
    bus.payloadReady = 1'b1;
    while (scoreboard.size() > 0 && budget > 0) begin
      if (bus.payloadValid) begin
        expHead = scoreboard.pop_front();
        checkOutput("payload", 32'({bus.payloadOut, bus.payloadAscii, bus.payloadLast}), 32'(expHead));
      end
      @(posedge clk); #1;
      budget--;
    end
    bus.payloadReady = 1'b0;
    checkOutput("drainPending", 32'(scoreboard.size()), 32'(0));
    checkOutput("drainEmpty", 32'(bus.payloadValid), 32'(0));
  endtask

  initial begin
    bus.dataIn             = 1'b0;
    bus.dataValid          = 1'b0;
    bus.readyForTransferIn = 1'b1;
    bus.payloadReady       = 1'b0;

    idleCycles(2);
    checkOutput("rstReady", 32'(bus.readyForTransferOut), 32'(0));
    checkOutput("rstScanner", 32'(bus.localScannerOut), 32'(0));
    checkOutput("rstValid", 32'(bus.payloadValid), 32'(0));
    checkOutput("rstErr", 32'(bus.errPulse), 32'(0));
    checkOutput("rstStatus", 32'(bus.statusReq), 32'(0));
    rst = 1'b1;
    idleCycles(2);
    checkOutput("postRstReady", 32'(bus.readyForTransferOut), 32'(0));

    // Start-scan command enables transfer one cycle after the scanner pulse.
    applyStimulus(8'h03);
    checkOutput("scanPulse", 32'(bus.localScannerOut), 32'(2'b01));
    checkOutput("readyLag", 32'(bus.readyForTransferOut), 32'(0));
    idleCycles(1);
    checkOutput("scanRevert", 32'(bus.localScannerOut), 32'(2'b00));
    checkOutput("readyOn", 32'(bus.readyForTransferOut), 32'(1));

    // Binary frame of three words, then a status command proves the FSM is back in CMD.
    applyStimulus(8'h07);
    applyStimulus(8'h03);
    applyStimulus(8'hA1); pushExpected(8'hA1, 1'b0, 1'b0);
    applyStimulus(8'hB2); pushExpected(8'hB2, 1'b0, 1'b0);
    applyStimulus(8'hC3); pushExpected(8'hC3, 1'b0, 1'b1);
    checkOutput("binErr", 32'(bus.errPulse), 32'(0));
    applyStimulus(8'h06);
    checkOutput("statusPulse", 32'(bus.statusReq), 32'(1));
    idleCycles(1);
    checkOutput("statusRevert", 32'(bus.statusReq), 32'(0));
    drainPayload();

    // ASCII frame with a high-bit word.
    applyStimulus(8'h08);
    applyStimulus(8'h02);
    applyStimulus(8'h41); pushExpected(8'h41, 1'b1, 1'b0);
    checkOutput("asciiOk", 32'(bus.errPulse), 32'(0));
    applyStimulus(8'hC1); pushExpected(8'hC1, 1'b1, 1'b1);
    checkOutput("asciiMsbErr", 32'(bus.errPulse), 32'(3'b010));
    drainPayload();

    // Fill the FIFO, overflow it, then push and pop on a full FIFO.
    applyStimulus(8'h07);
    applyStimulus(8'h10);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'(8'h20 + i));
      pushExpected(8'(8'h20 + i), 1'b0, i == 15);
    end
    checkOutput("fullNoErr", 32'(bus.errPulse), 32'(0));
    applyStimulus(8'h07);
    applyStimulus(8'h01);
    applyStimulus(8'hEE);
    checkOutput("overflow", 32'(bus.errPulse), 32'(3'b100));
    applyStimulus(8'h07);
    applyStimulus(8'h01);
    applyStimulus(8'hDD, 1'b1); pushExpected(8'hDD, 1'b0, 1'b1);
    checkOutput("pushPopFull", 32'(bus.errPulse), 32'(0));
    drainPayload();

    // Timeout mid-word, then a flush command decodes from a clean bit counter.
    sendBits(5);
    idleCycles(63);
    checkOutput("preTimeout", 32'(bus.errPulse), 32'(0));
    idleCycles(1);
    checkOutput("wordTimeout", 32'(bus.errPulse), 32'(3'b010));
    applyStimulus(8'h01);
    checkOutput("flushPulse", 32'(bus.localScannerOut), 32'(2'b10));
    checkOutput("flushReadyLag", 32'(bus.readyForTransferOut), 32'(1));
    idleCycles(1);
    checkOutput("flushReadyOff", 32'(bus.readyForTransferOut), 32'(0));

    // Timeout mid-frame keeps the word already queued, without a last marker.
    applyStimulus(8'h07);
    applyStimulus(8'h03);
    applyStimulus(8'h5A); pushExpected(8'h5A, 1'b0, 1'b0);
    idleCycles(64);
    checkOutput("frameTimeout", 32'(bus.errPulse), 32'(3'b010));
    drainPayload();

    // Command and length errors.
    applyStimulus(8'h09);
    checkOutput("cmdErr9", 32'(bus.errPulse), 32'(3'b001));
    applyStimulus(8'h00);
    checkOutput("cmdErr0", 32'(bus.errPulse), 32'(3'b001));
    applyStimulus(8'h07);
    applyStimulus(8'h00);
    checkOutput("lenZero", 32'(bus.errPulse), 32'(3'b010));
    applyStimulus(8'h07);
    applyStimulus(8'h11);
    checkOutput("lenTooBig", 32'(bus.errPulse), 32'(3'b010));

    // Asynchronous reset in the middle of a frame and a word.
    applyStimulus(8'h02);
    applyStimulus(8'h07);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    sendBits(3);
    checkOutput("preRstValid", 32'(bus.payloadValid), 32'(1));
    checkOutput("preRstReady", 32'(bus.readyForTransferOut), 32'(1));
    #2 rst = 1'b0;
    #1;
    checkOutput("midRstValid", 32'(bus.payloadValid), 32'(0));
    checkOutput("midRstData", 32'(bus.payloadOut), 32'(0));
    checkOutput("midRstReady", 32'(bus.readyForTransferOut), 32'(0));
    checkOutput("midRstErr", 32'(bus.errPulse), 32'(0));
    scoreboard.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    idleCycles(1);
    checkOutput("afterRstReady", 32'(bus.readyForTransferOut), 32'(0));
    applyStimulus(8'h07);
    applyStimulus(8'h01);
    applyStimulus(8'h55); pushExpected(8'h55, 1'b0, 1'b1);
    drainPayload();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end
endmodule
